// File: rtl/pattern_harness_pkg.sv
// Shared types and constants for the pattern-merge harness.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pattern_harness_pkg;

   // Width of the pattern_3_8-class primary-output vector.
   localparam int PATTERN_OUT_W = 9;

   // CRC-CCITT style taps; the x^16 term is implicit.
   localparam logic [15:0] DEFAULT_POLY = 16'h1021;
   localparam logic [15:0] DEFAULT_SEED = 16'h0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WARMUP,
      ST_CAPTURE,
      ST_COMPARE,
      ST_DONE
   } cap_state_t;

endpackage

// File: rtl/pattern_misr.sv
// Multiple-input signature register: shifts left, folds the MSB back through
// the taps and XORs in the zero-extended input word.
// Latency: 1 cycle per compacted word. Backpressure: none, i_enable qualifies data.
// Ports: i_clk/i_rst (sync, active-high, loads seed), i_load (loads seed),
//        i_enable (compact i_data), i_seed, i_poly, o_sig (register contents).
module pattern_misr
   import pattern_harness_pkg::*;
#(
   parameter int IN_W  = PATTERN_OUT_W,
   parameter int SIG_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_enable,
   input  logic [IN_W-1:0]  i_data,
   input  logic [SIG_W-1:0] i_seed,
   input  logic [SIG_W-1:0] i_poly,
   output logic [SIG_W-1:0] o_sig
);

   logic [SIG_W-1:0] r_sig;
   logic [SIG_W-1:0] w_data_ext;
   logic [SIG_W-1:0] w_next;

   // Zero-extension written per bit so SIG_W == IN_W needs no special case.
   always_comb begin
      w_data_ext             = '0;
      w_data_ext[IN_W-1:0]   = i_data;
      w_next = {r_sig[SIG_W-2:0], 1'b0}
             ^ (r_sig[SIG_W-1] ? i_poly : '0)
             ^ w_data_ext;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_load) begin
         r_sig <= i_seed;
      end else if (i_enable) begin
         r_sig <= w_next;
      end
   end

   assign o_sig = r_sig;

endmodule

// File: rtl/pattern_response_capture.sv
// Captures a pattern block's outputs into a MISR and compares with a golden signature.
// Latency: done rises one cycle after the final valid sample's edge.
// Backpressure: none; resp_valid qualifies each sample, start while busy is dropped.
// Ports: blif_clk_net, blif_reset_net (sync, active-high); start/abort control;
//        num_samples/golden_sig latched on start; resp_valid/resp_data input stream;
//        busy/done/pass status and signature/sample_count debug, all registered.
module pattern_response_capture
   import pattern_harness_pkg::*;
#(
   parameter int               IN_W   = PATTERN_OUT_W,
   parameter int               SIG_W  = 16,
   parameter int               CNT_W  = 16,
   parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEFAULT_POLY),
   parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEFAULT_SEED),
   parameter int               WARMUP = 2
) (
   input  logic             blif_clk_net,
   input  logic             blif_reset_net,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] num_samples,
   input  logic [SIG_W-1:0] golden_sig,
   input  logic             resp_valid,
   input  logic [IN_W-1:0]  resp_data,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature,
   output logic [CNT_W-1:0] sample_count
);

   localparam int              WU_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam logic [WU_W-1:0] WU_LAST = WU_W'((WARMUP > 0) ? WARMUP - 1 : 0);

   cap_state_t       r_state;
   logic [CNT_W-1:0] r_num;
   logic [SIG_W-1:0] r_golden;
   logic [CNT_W-1:0] r_cnt;
   logic [WU_W-1:0]  r_wu;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;

   logic             w_start_ok;
   logic             w_in_run;
   logic             w_misr_en;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [SIG_W-1:0] w_sig;

   assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);
   assign w_in_run   = (r_state == ST_WARMUP) || (r_state == ST_CAPTURE) ||
                       (r_state == ST_COMPARE);
   // An abort in the same cycle as a valid sample must leave the MISR untouched.
   assign w_misr_en  = (r_state == ST_CAPTURE) && resp_valid && !abort;
   assign w_cnt_inc  = r_cnt + 1'b1;

   pattern_misr #(
      .IN_W  (IN_W),
      .SIG_W (SIG_W)
   ) u_misr (
      .i_clk    (blif_clk_net),
      .i_rst    (blif_reset_net),
      .i_load   (w_start_ok),
      .i_enable (w_misr_en),
      .i_data   (resp_data),
      .i_seed   (SEED),
      .i_poly   (POLY),
      .o_sig    (w_sig)
   );

   always_ff @(posedge blif_clk_net) begin
      if (blif_reset_net) begin
         r_state  <= ST_IDLE;
         r_num    <= '0;
         r_golden <= '0;
         r_cnt    <= '0;
         r_wu     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_pass   <= 1'b0;
      end else if (abort && w_in_run) begin
         // Counters and signature are kept for post-mortem inspection.
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_num    <= num_samples;
                  r_golden <= golden_sig;
                  r_cnt    <= '0;
                  r_wu     <= '0;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
                  r_pass   <= 1'b0;
                  // A zero-length run with no warmup still needs the compare cycle.
                  if (WARMUP > 0)
                     r_state <= ST_WARMUP;
                  else if (num_samples == '0)
                     r_state <= ST_COMPARE;
                  else
                     r_state <= ST_CAPTURE;
               end
            end
            ST_WARMUP: begin
               if (r_wu == WU_LAST)
                  r_state <= (r_num == '0) ? ST_COMPARE : ST_CAPTURE;
               else
                  r_wu <= r_wu + 1'b1;
            end
            ST_CAPTURE: begin
               if (resp_valid) begin
                  r_cnt <= w_cnt_inc;
                  if (w_cnt_inc == r_num)
                     r_state <= ST_COMPARE;
               end
            end
            ST_COMPARE: begin
               r_pass  <= (w_sig == r_golden);
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_DONE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy         = r_busy;
   assign done         = r_done;
   assign pass         = r_pass;
   assign signature    = w_sig;
   assign sample_count = r_cnt;

endmodule

// File: tb/tb_pattern_response_capture.sv
// Self-checking bench for pattern_response_capture: directed scenarios plus
// randomized runs scored against a polynomial-arithmetic signature model.
// Two instances share stimulus; the second uses a non-zero seed to reach the taps.
module tb_pattern_response_capture;

   localparam logic [15:0] POLY = 16'h1021;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [15:0] num;
   logic [15:0] golden;
   logic        rv;
   logic [8:0]  rd;

   logic        busy, done, pass;
   logic [15:0] sig, cnt;
   logic        busy2, done2, pass2;
   logic [15:0] sig2, cnt2;

   int checks = 0;
   int errors = 0;

   pattern_response_capture dut (
      .blif_clk_net   (clk),
      .blif_reset_net (rst),
      .start          (start),
      .abort          (abort),
      .num_samples    (num),
      .golden_sig     (golden),
      .resp_valid     (rv),
      .resp_data      (rd),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .signature      (sig),
      .sample_count   (cnt)
   );

   pattern_response_capture #(.SEED(16'h8000)) dut2 (
      .blif_clk_net   (clk),
      .blif_reset_net (rst),
      .start          (start),
      .abort          (abort),
      .num_samples    (num),
      .golden_sig     (golden),
      .resp_valid     (rv),
      .resp_data      (rd),
      .busy           (busy2),
      .done           (done2),
      .pass           (pass2),
      .signature      (sig2),
      .sample_count   (cnt2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Signature as a GF(2) polynomial: multiply by x, reduce modulo x^16+POLY,
   // then add the new sample.
   function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [8:0] d);
      logic [16:0] p;
      p = {s, 1'b0};
      if (p[16]) p = p ^ {1'b1, POLY};
      return p[15:0] ^ {7'd0, d};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [15:0] n, input logic [15:0] g);
      num = n; golden = g; start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1; num = 16'd3;
      tick; tick;
      start = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b want 0", pass); end
      checks++; if (sig !== 16'h0000) begin errors++; $display("FAIL reset_sig: got %h want 0000", sig); end
      checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
      checks++; if (sig2 !== 16'h8000) begin errors++; $display("FAIL reset_sig2: got %h want 8000", sig2); end
      rst = 1'b0;
      tick;
   endtask

   task automatic test_single;
      do_start(16'd1, 16'h01FF);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_start: got %b want 1", busy); end
      // Valid data during warmup must be discarded.
      rv = 1'b1; rd = 9'h0AA;
      tick; tick;
      rv = 1'b1; rd = 9'h1FF;
      tick;
      rv = 1'b0;
      checks++; if (sig !== 16'h01FF) begin errors++; $display("FAIL single_sig: got %h want 01FF", sig); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_early: got %b want 0", done); end
      tick;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", done); end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL single_pass: got %b want 1", pass); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
      // Abort while in DONE leaves the verdict alone.
      abort = 1'b1;
      tick;
      abort = 1'b0;
      checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL done_abort_ignored: got done=%b pass=%b want 1 1", done, pass); end
   endtask

   task automatic test_shift_gaps;
      do_start(16'd2, 16'h0003);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL gaps_done_clear: got %b want 0", done); end
      tick; tick;
      rv = 1'b1; rd = 9'h001;
      tick;
      rv = 1'b0;
      for (int i = 0; i < 3; i++) begin
         // A start mid-run must not relatch num_samples/golden_sig.
         start = (i == 1); num = 16'd1; golden = 16'h0002;
         tick;
      end
      start = 1'b0;
      checks++; if (cnt !== 16'd1 || sig !== 16'h0001) begin errors++; $display("FAIL gaps_hold: got cnt=%0d sig=%h want 1 0001", cnt, sig); end
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL gaps_busy: got busy=%b done=%b want 1 0", busy, done); end
      rv = 1'b1; rd = 9'h000;
      tick;
      rv = 1'b0;
      checks++; if (sig !== 16'h0002) begin errors++; $display("FAIL gaps_sig: got %h want 0002", sig); end
      checks++; if (cnt !== 16'd2) begin errors++; $display("FAIL gaps_cnt: got %0d want 2", cnt); end
      tick;
      checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL gaps_verdict: got done=%b pass=%b want 1 0", done, pass); end
   endtask

   task automatic test_feedback;
      do_start(16'd1, 16'h1021);
      tick; tick;
      rv = 1'b1; rd = 9'h000;
      tick;
      rv = 1'b0;
      checks++; if (sig2 !== 16'h1021) begin errors++; $display("FAIL feedback_sig: got %h want 1021", sig2); end
      checks++; if (sig !== 16'h0000) begin errors++; $display("FAIL feedback_sig_seed0: got %h want 0000", sig); end
      tick;
      checks++; if (done2 !== 1'b1 || pass2 !== 1'b1) begin errors++; $display("FAIL feedback_verdict: got done=%b pass=%b want 1 1", done2, pass2); end
   endtask

   task automatic test_zero_samples;
      rv = 1'b1; rd = 9'h155;
      do_start(16'd0, 16'h0000);
      tick;
      tick;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_early: got %b want 0", done); end
      tick;
      rv = 1'b0;
      checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL zero_verdict: got done=%b pass=%b want 1 1", done, pass); end
      checks++; if (cnt !== 16'd0 || sig !== 16'h0000) begin errors++; $display("FAIL zero_state: got cnt=%0d sig=%h want 0 0000", cnt, sig); end
   endtask

   task automatic test_abort_priority;
      logic [8:0] d0;
      d0 = 9'($urandom_range(1, 511));
      do_start(16'd4, 16'h0000);
      tick; tick;
      rv = 1'b1; rd = d0;
      tick;
      abort = 1'b1; start = 1'b1; num = 16'd1; rd = 9'h1FF;
      tick;
      abort = 1'b0; start = 1'b0; rv = 1'b0;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL abort_flags: got busy=%b done=%b pass=%b want 0 0 0", busy, done, pass); end
      checks++; if (cnt !== 16'd1 || sig !== {7'd0, d0}) begin errors++; $display("FAIL abort_hold: got cnt=%0d sig=%h want 1 %h", cnt, sig, {7'd0, d0}); end
      do_start(16'd1, ref_step(16'h0000, 9'h0C3));
      checks++; if (busy !== 1'b1 || cnt !== 16'd0 || sig !== 16'h0000) begin errors++; $display("FAIL restart_state: got busy=%b cnt=%0d sig=%h want 1 0 0000", busy, cnt, sig); end
      tick; tick;
      rv = 1'b1; rd = 9'h0C3;
      tick;
      rv = 1'b0;
      tick;
      checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL restart_verdict: got done=%b pass=%b want 1 1", done, pass); end
   endtask

   task automatic test_midrun_reset;
      do_start(16'd4, 16'h0000);
      tick; tick;
      rv = 1'b1; rd = 9'h07F;
      tick;
      rst = 1'b1; start = 1'b1; abort = 1'b0;
      tick;
      rst = 1'b0; start = 1'b0; rv = 1'b0;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL midreset_flags: got busy=%b done=%b pass=%b want 0 0 0", busy, done, pass); end
      checks++; if (cnt !== 16'd0 || sig !== 16'h0000) begin errors++; $display("FAIL midreset_state: got cnt=%0d sig=%h want 0 0000", cnt, sig); end
      tick;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_start_dropped: got busy=%b want 0", busy); end
   endtask

   task automatic test_random;
      logic [8:0]  dq [8];
      logic [15:0] exp1, exp2, g;
      int          n, idx, budget;
      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(1, 8);
         exp1 = 16'h0000; exp2 = 16'h8000;
         for (int k = 0; k < n; k++) begin
            dq[k] = 9'($urandom);
            exp1 = ref_step(exp1, dq[k]);
            exp2 = ref_step(exp2, dq[k]);
         end
         g = ($urandom_range(0, 1) == 1) ? exp1 : (exp1 ^ (16'd1 << $urandom_range(0, 15)));
         do_start(16'(n), g);
         for (int w = 0; w < 2; w++) begin
            rv = 1'($urandom); rd = 9'($urandom);
            tick;
         end
         checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL rand_warmup_cnt run%0d: got %0d want 0", r, cnt); end
         idx = 0; budget = 0;
         while (idx < n && budget < 100) begin
            rv = 1'($urandom_range(0, 1));
            rd = rv ? dq[idx] : 9'($urandom);
            start = ($urandom_range(0, 5) == 0); num = 16'd1;
            tick;
            if (rv) idx++;
            budget++;
            checks++; if (cnt !== 16'(idx)) begin errors++; $display("FAIL rand_cnt run%0d: got %0d want %0d", r, cnt, idx); end
         end
         start = 1'b0; rv = 1'b0;
         checks++; if (idx != n) begin errors++; $display("FAIL rand_budget run%0d: got %0d samples want %0d", r, idx, n); end
         checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rand_compare_cycle run%0d: got done=%b busy=%b want 0 1", r, done, busy); end
         tick;
         checks++; if (sig !== exp1 || sig2 !== exp2) begin errors++; $display("FAIL rand_sig run%0d: got %h/%h want %h/%h", r, sig, sig2, exp1, exp2); end
         checks++; if (done !== 1'b1 || busy !== 1'b0 || pass !== (g == exp1)) begin errors++; $display("FAIL rand_verdict run%0d: got done=%b busy=%b pass=%b want 1 0 %b", r, done, busy, pass, (g == exp1)); end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      num = 16'd0; golden = 16'd0; rv = 1'b0; rd = 9'd0;
      test_reset;
      test_single;
      test_shift_gaps;
      test_feedback;
      test_zero_samples;
      test_abort_priority;
      test_midrun_reset;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
